// File: rtl/matmul_calc_pkg.sv
// Shared parameters and types for the matmul_calc datapath.
// Holds the element/bus widths plus the operand feeder's dimension, lane and state types.
package matmul_calc_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BUS_WIDTH  = 64;

  // Array edge length: one load word carries exactly one full matrix row.
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int DIM_W   = $clog2(MAX_DIM) + 1;
  localparam int IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int BEAT_W  = $clog2(2 * MAX_DIM) + 1;

  typedef logic [DIM_W-1:0]      dim_t;
  typedef logic [BEAT_W-1:0]     beat_t;
  typedef logic [DATA_WIDTH-1:0] elem_t;

  typedef logic [MAX_DIM-1:0][DATA_WIDTH-1:0] lane_vec_t;

  // Indexed [row][col].
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matA;
  typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_WIDTH-1:0] matB;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } feeder_state_e;

  function automatic logic dimOk(input dim_t d);
    return (d != '0) && (d <= dim_t'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matmul_operand_feeder_if.sv
// Control, load and stream signals of the operand feeder.
// The slave modport is the feeder itself; the master modport is its environment.
interface matmul_operand_feeder_if;
  import matmul_calc_pkg::*;

  logic                 start_i;
  dim_t                 n_dim_i;
  dim_t                 k_dim_i;
  dim_t                 m_dim_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [BUS_WIDTH-1:0] in_data_i;
  lane_vec_t            a_left_o;
  lane_vec_t            b_top_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 first_o;
  logic                 last_o;
  logic                 busy_o;
  logic                 cfg_err_o;

  modport slave (
    input  start_i, n_dim_i, k_dim_i, m_dim_i,
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, a_left_o, b_top_o, out_valid_o,
    output first_o, last_o, busy_o, cfg_err_o
  );

  modport master (
    output start_i, n_dim_i, k_dim_i, m_dim_i,
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, a_left_o, b_top_o, out_valid_o,
    input  first_o, last_o, busy_o, cfg_err_o
  );

endinterface

// File: rtl/matmul_operand_buf.sv
// MAX_DIM x MAX_DIM operand register file with a masked row write port and a skewed read port.
// COL_LANES=0 gives lane l = mem[l][t-l] (A, rows); COL_LANES=1 gives lane l = mem[t-l][l] (B, columns).
module matmul_operand_buf
  import matmul_calc_pkg::*;
#(
  parameter type mat_t     = matA,
  parameter bit  COL_LANES = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear,
  input  logic                 wrEn,
  input  logic [IDX_W-1:0]     wrRow,
  input  logic [BUS_WIDTH-1:0] wrData,
  input  dim_t                 wrCols,
  input  beat_t                rdBeat,
  input  dim_t                 rdDepth,
  input  dim_t                 rdLanes,
  output lane_vec_t            lanes
);

  mat_t mem;
  mat_t memNext;

  // NOTE: every always_comb target gets a full default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    memNext = mem;
    if (clear) begin
      memNext = '0;
    end else if (wrEn) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        memNext[wrRow][c] = (dim_t'(c) < wrCols) ? wrData[c*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment only; blocking here would race with other clocked readers.
  // NOTE: the register file takes the async reset like any other state, so an aborted run leaves no operand behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem <= '0;
    end else begin
      mem <= memNext;
    end
  end

  // Reads look at memNext so a row written this cycle is visible to the beat registered at the same edge.
  always_comb begin
    lanes = '0;
    for (int l = 0; l < MAX_DIM; l++) begin
      if ((rdBeat >= beat_t'(l)) &&
          ((rdBeat - beat_t'(l)) < beat_t'(rdDepth)) &&
          (beat_t'(l) < beat_t'(rdLanes))) begin
        if (COL_LANES) begin
          lanes[l] = memNext[IDX_W'(rdBeat - beat_t'(l))][l];
        end else begin
          lanes[l] = memNext[l][IDX_W'(rdBeat - beat_t'(l))];
        end
      end
    end
  end

endmodule

// File: rtl/matmul_operand_feeder.sv
// Operand feeder for the matmul_calc systolic array: loads A (N x K) and B (K x M) one row per word,
// then streams them diagonally skewed into the array's left and top edges with first/last marking.
module matmul_operand_feeder
  import matmul_calc_pkg::*;
(
  input logic                    clk_i,
  input logic                    rst_ni,
  matmul_operand_feeder_if.slave bus
);

  feeder_state_e state;
  feeder_state_e stateNext;

  dim_t      nDim;
  dim_t      kDim;
  dim_t      mDim;
  dim_t      maxNm;
  beat_t     loadCnt;
  beat_t     beatIdx;
  beat_t     lastBeat;
  beat_t     rdBeat;
  logic      inReady;
  logic      outValid;
  logic      firstBeat;
  logic      finalBeat;
  logic      busy;
  logic      cfgErr;
  lane_vec_t aLeft;
  lane_vec_t bTop;
  lane_vec_t aLanes;
  lane_vec_t bLanes;

  logic dimsOk;
  logic startOk;
  logic accept;
  logic loadDone;
  logic handshake;
  logic aWrEn;
  logic bWrEn;

  assign dimsOk    = dimOk(bus.n_dim_i) && dimOk(bus.k_dim_i) && dimOk(bus.m_dim_i);
  assign startOk   = (state == IDLE) && bus.start_i && dimsOk;
  assign maxNm     = (bus.n_dim_i > bus.m_dim_i) ? bus.n_dim_i : bus.m_dim_i;
  assign accept    = inReady && bus.in_valid_i;
  assign loadDone  = accept && (loadCnt == beat_t'(nDim) + beat_t'(kDim) - beat_t'(1));
  assign handshake = outValid && bus.out_ready_i;
  assign aWrEn     = accept && (loadCnt < beat_t'(nDim));
  assign bWrEn     = accept && !aWrEn;

  // The beat being registered next: beat 0 when leaving LOAD, otherwise the one after the displayed beat.
  assign rdBeat = (state == LOAD) ? '0 : beatIdx + beat_t'(1);

  matmul_operand_buf #(
    .mat_t    (matA),
    .COL_LANES(1'b0)
  ) u_buf_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (startOk),
    .wrEn   (aWrEn),
    .wrRow  (IDX_W'(loadCnt)),
    .wrData (bus.in_data_i),
    .wrCols (kDim),
    .rdBeat (rdBeat),
    .rdDepth(kDim),
    .rdLanes(nDim),
    .lanes  (aLanes)
  );

  matmul_operand_buf #(
    .mat_t    (matB),
    .COL_LANES(1'b1)
  ) u_buf_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (startOk),
    .wrEn   (bWrEn),
    .wrRow  (IDX_W'(loadCnt - beat_t'(nDim))),
    .wrData (bus.in_data_i),
    .wrCols (mDim),
    .rdBeat (rdBeat),
    .rdDepth(kDim),
    .rdLanes(mDim),
    .lanes  (bLanes)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startOk) stateNext = LOAD;
      LOAD:    if (loadDone) stateNext = STREAM;
      STREAM:  if (handshake && finalBeat) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Status flags are registered from the next state, so no input reaches an output combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nDim      <= '0;
      kDim      <= '0;
      mDim      <= '0;
      loadCnt   <= '0;
      beatIdx   <= '0;
      lastBeat  <= '0;
      inReady   <= 1'b0;
      outValid  <= 1'b0;
      firstBeat <= 1'b0;
      finalBeat <= 1'b0;
      busy      <= 1'b0;
      cfgErr    <= 1'b0;
      aLeft     <= '0;
      bTop      <= '0;
    end else begin
      inReady <= (stateNext == LOAD);
      busy    <= (stateNext != IDLE);
      cfgErr  <= (state == IDLE) && bus.start_i && !dimsOk;

      if (startOk) begin
        nDim     <= bus.n_dim_i;
        kDim     <= bus.k_dim_i;
        mDim     <= bus.m_dim_i;
        loadCnt  <= '0;
        lastBeat <= beat_t'(bus.k_dim_i) + beat_t'(maxNm) - beat_t'(2);
      end else if (accept) begin
        loadCnt <= loadCnt + beat_t'(1);
      end

      if (loadDone) begin
        outValid  <= 1'b1;
        firstBeat <= 1'b1;
        finalBeat <= (lastBeat == '0);
        beatIdx   <= '0;
        aLeft     <= aLanes;
        bTop      <= bLanes;
      end else if (handshake) begin
        if (finalBeat) begin
          outValid  <= 1'b0;
          firstBeat <= 1'b0;
          finalBeat <= 1'b0;
          aLeft     <= '0;
          bTop      <= '0;
        end else begin
          beatIdx   <= rdBeat;
          firstBeat <= 1'b0;
          finalBeat <= (rdBeat == lastBeat);
          aLeft     <= aLanes;
          bTop      <= bLanes;
        end
      end
    end
  end

  assign bus.in_ready_o  = inReady;
  assign bus.out_valid_o = outValid;
  assign bus.first_o     = firstBeat;
  assign bus.last_o      = finalBeat;
  assign bus.busy_o      = busy;
  assign bus.cfg_err_o   = cfgErr;
  assign bus.a_left_o    = aLeft;
  assign bus.b_top_o     = bTop;

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Scoreboard bench for matmul_operand_feeder: expected beats are queued as each run is launched
// and compared against the stream outputs on every falling edge while out_valid_o is high.
module tb_matmul_operand_feeder;
  import matmul_calc_pkg::*;

  typedef struct packed {
    lane_vec_t a;
    lane_vec_t b;
    logic      first;
    logic      last;
  } exp_beat_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  exp_beat_t            sb[$];
  logic [BUS_WIDTH-1:0] words[2*MAX_DIM];

  matmul_operand_feeder_if bus ();

  matmul_operand_feeder dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic lane_vec_t mk(input int l0, input int l1);
    lane_vec_t v;
    v    = '0;
    v[0] = DATA_WIDTH'(l0);
    v[1] = DATA_WIDTH'(l1);
    return v;
  endfunction

  task automatic push_beat(input lane_vec_t a, input lane_vec_t b, input logic f, input logic l);
    exp_beat_t e;
    e.a = a;
    e.b = b;
    e.first = f;
    e.last = l;
    sb.push_back(e);
  endtask

  // Reference model straight from the skew definition, reading the raw load words.
  task automatic push_model(input int n, input int k, input int m);
    int len;
    len = k + ((n > m) ? n : m) - 1;
    for (int t = 0; t < len; t++) begin
      exp_beat_t e;
      e = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
        int c;
        c = t - i;
        if (c >= 0 && c < k && i < n) e.a[i] = words[i][c*DATA_WIDTH +: DATA_WIDTH];
        if (c >= 0 && c < k && i < m) e.b[i] = words[n+c][i*DATA_WIDTH +: DATA_WIDTH];
      end
      e.first = (t == 0);
      e.last  = (t == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic set_words_case1();
    words[0] = {32'd2, 32'd1};
    words[1] = {32'd4, 32'd3};
    words[2] = {32'd6, 32'd5};
    words[3] = {32'd8, 32'd7};
  endtask

  task automatic push_case1();
    push_beat(mk(1, 0), mk(5, 0), 1'b1, 1'b0);
    push_beat(mk(2, 3), mk(7, 6), 1'b0, 1'b0);
    push_beat(mk(0, 4), mk(0, 8), 1'b0, 1'b1);
  endtask

  task automatic start_pulse(input int n, input int k, input int m);
    bus.n_dim_i = dim_t'(n);
    bus.k_dim_i = dim_t'(k);
    bus.m_dim_i = dim_t'(m);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic load_words(input int cnt, input bit gaps);
    for (int w = 0; w < cnt; w++) begin
      int   waited;
      logic rdy;
      waited = 0;
      rdy = 1'b0;
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = words[w];
      do begin
        @(negedge clk);
        rdy = bus.in_ready_o;
        @(posedge clk); #1;
        waited++;
      end while (!rdy && waited < 50);
      check("load_accept", rdy, 1'b1);
      if (gaps) begin
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '1;
        @(posedge clk); #1;
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    int doneCycles;
    cyc = 0;
    doneCycles = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.busy_o && !bus.out_valid_o) doneCycles++;
    end while (bus.busy_o && cyc < 200);
    check("busy_falls", bus.busy_o, 1'b0);
    check("done_cycles", doneCycles, 1);
    check("idle_out_valid", bus.out_valid_o, 1'b0);
    check("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Compares the displayed beat with the queue head every cycle; pops only on a handshake,
  // so a stalled beat is re-checked each cycle it is held.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o) begin
      check("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        check("a_left", bus.a_left_o, sb[0].a);
        check("b_top", bus.b_top_o, sb[0].b);
        check("first", bus.first_o, sb[0].first);
        check("last", bus.last_o, sb[0].last);
        if (bus.out_ready_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.n_dim_i = '0;
    bus.k_dim_i = '0;
    bus.m_dim_i = '0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i = '0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready_o, 1'b0);
    check("rst_out_valid", bus.out_valid_o, 1'b0);
    check("rst_first", bus.first_o, 1'b0);
    check("rst_last", bus.last_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_cfg_err", bus.cfg_err_o, 1'b0);
    check("rst_a_left", bus.a_left_o, '0);
    check("rst_b_top", bus.b_top_o, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Load words offered in IDLE are not accepted.
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = '1;
    @(posedge clk); #1;
    check("idle_in_ready", bus.in_ready_o, 1'b0);
    check("idle_busy", bus.busy_o, 1'b0);
    bus.in_valid_i = 1'b0;

    // Case 1: full 2x2 by 2x2.
    set_words_case1();
    push_case1();
    start_pulse(2, 2, 2);
    check("load_busy", bus.busy_o, 1'b1);
    load_words(4, 1'b0);
    wait_done();

    // Case 2: N=2, K=1, M=1, upper lanes masked.
    words[0] = {32'd9, 32'd1};
    words[1] = {32'd9, 32'd3};
    words[2] = {32'd9, 32'd5};
    push_beat(mk(1, 0), mk(5, 0), 1'b1, 1'b0);
    push_beat(mk(0, 3), mk(0, 0), 1'b0, 1'b1);
    start_pulse(2, 1, 1);
    load_words(3, 1'b0);
    wait_done();

    // Case 3: stall at t=1 for four cycles.
    set_words_case1();
    push_case1();
    start_pulse(2, 2, 2);
    load_words(4, 1'b0);
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_valid", bus.out_valid_o, 1'b1);
    bus.out_ready_i = 1'b1;
    wait_done();

    // Case 4a: illegal dims raise a one-cycle cfg_err_o and never leave IDLE.
    start_pulse(2, 0, 2);
    @(negedge clk);
    check("cfg_err_k0", bus.cfg_err_o, 1'b1);
    check("cfg_err_k0_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    check("cfg_err_k0_pulse", bus.cfg_err_o, 1'b0);
    check("cfg_err_k0_idle", bus.busy_o, 1'b0);
    @(posedge clk); #1;
    start_pulse(3, 1, 1);
    @(negedge clk);
    check("cfg_err_n3", bus.cfg_err_o, 1'b1);
    check("cfg_err_n3_busy", bus.busy_o, 1'b0);
    @(posedge clk); #1;

    // Case 4b: start_i and in_valid_i during STREAM are ignored.
    set_words_case1();
    push_case1();
    start_pulse(2, 2, 2);
    load_words(4, 1'b0);
    bus.n_dim_i = dim_t'(1);
    bus.k_dim_i = dim_t'(1);
    bus.m_dim_i = dim_t'(1);
    bus.start_i = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.in_data_i = {32'd77, 32'd66};
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check("stream_in_ready", bus.in_ready_o, 1'b0);
    bus.in_valid_i = 1'b0;
    wait_done();
    check("stray_start_idle", bus.busy_o, 1'b0);

    // Case 5: gaps on in_valid_i during LOAD.
    set_words_case1();
    push_case1();
    start_pulse(2, 2, 2);
    load_words(4, 1'b1);
    wait_done();

    // Extra model-checked shapes with random data.
    for (int r = 0; r < 2 * MAX_DIM; r++) words[r] = {$urandom, $urandom};
    push_model(1, 2, 2);
    start_pulse(1, 2, 2);
    load_words(3, 1'b0);
    wait_done();
    for (int r = 0; r < 2 * MAX_DIM; r++) words[r] = {$urandom, $urandom};
    push_model(2, 2, 1);
    start_pulse(2, 2, 1);
    load_words(4, 1'b0);
    wait_done();
    for (int r = 0; r < 2 * MAX_DIM; r++) words[r] = {$urandom, $urandom};
    push_model(1, 1, 1);
    start_pulse(1, 1, 1);
    load_words(2, 1'b0);
    wait_done();

    // Case 6: asynchronous reset in the middle of STREAM at t=1.
    set_words_case1();
    push_case1();
    start_pulse(2, 2, 2);
    load_words(4, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid_o, 1'b0);
    check("arst_a_left", bus.a_left_o, '0);
    check("arst_b_top", bus.b_top_o, '0);
    check("arst_first", bus.first_o, 1'b0);
    check("arst_last", bus.last_o, 1'b0);
    check("arst_busy", bus.busy_o, 1'b0);
    check("arst_in_ready", bus.in_ready_o, 1'b0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    set_words_case1();
    push_case1();
    start_pulse(2, 2, 2);
    load_words(4, 1'b0);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
